// File: rtl/register_file_32x32.sv
// ---------------------------------------------------------------------------
// register_file_32x32
//
// Purpose:
//   32-entry general-purpose register file for the 5-stage pipeline. The
//   write address is expanded into a one-hot row enable (gated by WRITE) so
//   that exactly one row loads per clock. Two registered read ports serve the
//   decode stage. Each port has a write-first bypass, so a read of the row
//   being written in the same cycle returns the new data.
//
// Ports:
//   CLK      in   1           rising-edge clock for all state
//   RST      in   1           synchronous active-low reset
//   WRITE    in   1           write request for this cycle
//   ADDR_W   in   ADDR_WIDTH  destination register address
//   DATA_W   in   DATA_WIDTH  write data
//   READ     in   1           read request; loads both output registers
//   ADDR_R1  in   ADDR_WIDTH  read port 1 address
//   ADDR_R2  in   ADDR_WIDTH  read port 2 address
//   DATA_R1  out  DATA_WIDTH  registered read data, port 1
//   DATA_R2  out  DATA_WIDTH  registered read data, port 2
// ---------------------------------------------------------------------------
module register_file_32x32 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  input  logic                  READ,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regFile_q [Depth];
  logic [Depth-1:0]      rowEnable;
  logic                  writeAllowed;
  logic [DATA_WIDTH-1:0] readData1_d;
  logic [DATA_WIDTH-1:0] readData2_d;
  logic [DATA_WIDTH-1:0] readData1_q;
  logic [DATA_WIDTH-1:0] readData2_q;

  // A write is effective only when requested and, with the zero register
  // enabled, not aimed at row 0. Row 0 is then never loaded after reset, so
  // it reads zero without needing any special case on the read side.
  always_comb begin
    writeAllowed = WRITE;
    if ((ZERO_REG != 0) && (ADDR_W == '0)) begin
      writeAllowed = 1'b0;
    end
  end

  // One-hot row enable: the 5-to-32 decode of ADDR_W, forced all-zero when
  // no effective write is taking place.
  always_comb begin
    rowEnable = '0;
    if (writeAllowed) begin
      rowEnable[ADDR_W] = 1'b1;
    end
  end

  // Row storage. Reset clears every row and takes priority over any write
  // pending at the same edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < Depth; i++) begin
        regFile_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Depth; i++) begin
        if (rowEnable[i]) begin
          regFile_q[i] <= DATA_W;
        end
      end
    end
  end

  // Read multiplexers with write-first bypass. Using writeAllowed for the
  // compare means a write to row 0 is never forwarded when the zero
  // register is active, so that port still returns zero.
  always_comb begin
    readData1_d = regFile_q[ADDR_R1];
    readData2_d = regFile_q[ADDR_R2];
    if (writeAllowed && (ADDR_R1 == ADDR_W)) begin
      readData1_d = DATA_W;
    end
    if (writeAllowed && (ADDR_R2 == ADDR_W)) begin
      readData2_d = DATA_W;
    end
  end

  // Output registers load only on READ, so they hold their last value while
  // READ is low, even if the row they came from is rewritten meanwhile.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      readData1_q <= '0;
      readData2_q <= '0;
    end else if (READ) begin
      readData1_q <= readData1_d;
      readData2_q <= readData2_d;
    end
  end

  assign DATA_R1 = readData1_q;
  assign DATA_R2 = readData2_q;

endmodule

// File: tb/tb_register_file_32x32.sv
// ---------------------------------------------------------------------------
// tb_register_file_32x32
//
// Self-checking bench for register_file_32x32. Two instances share all
// inputs: dutZero uses ZERO_REG=1 and dutPlain uses ZERO_REG=0. A behavioural
// model holds one plain array per instance and keeps the expected outputs.
// ---------------------------------------------------------------------------
module tb_register_file_32x32;

  logic        clock;
  logic        rstN;
  logic        writeEn;
  logic [4:0]  addrW;
  logic [31:0] dataW;
  logic        readEn;
  logic [4:0]  addrR1;
  logic [4:0]  addrR2;
  logic [31:0] zeroR1;
  logic [31:0] zeroR2;
  logic [31:0] plainR1;
  logic [31:0] plainR2;

  // Model state: register contents and expected outputs for each instance.
  logic [31:0] memZero  [32];
  logic [31:0] memPlain [32];
  logic [31:0] expZeroR1;
  logic [31:0] expZeroR2;
  logic [31:0] expPlainR1;
  logic [31:0] expPlainR2;

  logic [127:0] observed;
  logic [127:0] expected;

  int checks;
  int failures;

  register_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dutZero (
    .CLK(clock), .RST(rstN), .WRITE(writeEn), .ADDR_W(addrW), .DATA_W(dataW),
    .READ(readEn), .ADDR_R1(addrR1), .ADDR_R2(addrR2),
    .DATA_R1(zeroR1), .DATA_R2(zeroR2)
  );

  register_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dutPlain (
    .CLK(clock), .RST(rstN), .WRITE(writeEn), .ADDR_W(addrW), .DATA_W(dataW),
    .READ(readEn), .ADDR_R1(addrR1), .ADDR_R2(addrR2),
    .DATA_R1(plainR1), .DATA_R2(plainR2)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drives one cycle of inputs, waits for the edge, and advances the model.
  // Reads use the pre-edge contents, except that a row written in the same
  // cycle gives the new data. The outputs are sampled 1 ns after the edge.
  task automatic applyStimulus(input logic rst, input logic wr, input logic [4:0] aw,
                               input logic [31:0] dw, input logic rd,
                               input logic [4:0] a1, input logic [4:0] a2);
    rstN = rst; writeEn = wr; addrW = aw; dataW = dw;
    readEn = rd; addrR1 = a1; addrR2 = a2;
    @(posedge clock);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        memZero[i]  = 32'h0;
        memPlain[i] = 32'h0;
      end
      expZeroR1 = 32'h0; expZeroR2 = 32'h0;
      expPlainR1 = 32'h0; expPlainR2 = 32'h0;
    end else begin
      if (rd) begin
        expZeroR1  = (wr && a1 == aw && aw != 5'd0) ? dw : memZero[a1];
        expZeroR2  = (wr && a2 == aw && aw != 5'd0) ? dw : memZero[a2];
        expPlainR1 = (wr && a1 == aw) ? dw : memPlain[a1];
        expPlainR2 = (wr && a2 == aw) ? dw : memPlain[a2];
      end
      if (wr) begin
        if (aw != 5'd0) memZero[aw] = dw;
        memPlain[aw] = dw;
      end
    end
    #1;
    observed = {zeroR1, zeroR2, plainR1, plainR2};
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    checks++;
    if (observed !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_initial observed=%h required=%h", observed, 128'h0);
    end
    for (int n = 0; n < 10; n++) begin
      applyStimulus(1'b1, 1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), 5'($urandom));
      expected = {expZeroR1, expZeroR2, expPlainR1, expPlainR2};
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL reset_prefill_read observed=%h required=%h", observed, expected);
      end
    end
    applyStimulus(1'b0, 1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), 5'($urandom));
    checks++;
    if (observed !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_after_writes observed=%h required=%h", observed, 128'h0);
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
      checks++;
      if (observed !== 128'h0) begin
        failures++;
        $display("[TB] FAIL reset_read_all addr=%0d observed=%h required=%h", i, observed, 128'h0);
      end
    end
  endtask

  task automatic test_write_read_all();
    logic [31:0] val1;
    logic [31:0] val2;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(i), 32'hA5A50000 + 32'(i), 1'b0, 5'(i), 5'(i));
      checks++;
      if (observed !== 128'h0) begin
        failures++;
        $display("[TB] FAIL write_all_no_read addr=%0d observed=%h required=%h", i, observed, 128'h0);
      end
    end
    for (int i = 0; i < 32; i++) begin
      val1 = (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i);
      val2 = (i == 31) ? 32'h0 : 32'hA5A50000 + 32'(31 - i);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i));
      expected = {val1, val2, val1, val2};
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL read_all addr=%0d observed=%h required=%h", i, observed, expected);
      end
    end
    // Last read was ADDR_R1=31, ADDR_R2=0; outputs must hold with READ low.
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'(n + 2), 5'(n + 9));
      expected = {32'hA5A5001F, 32'h0, 32'hA5A5001F, 32'h0};
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL read_hold cycle=%0d observed=%h required=%h", n, observed, expected);
      end
    end
  endtask

  task automatic test_zero_reg();
    applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    expected = {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL zero_reg_read observed=%h required=%h", observed, expected);
    end
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd5);
    expected = {32'h0, 32'hA5A50005, 32'h12345678, 32'hA5A50005};
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL zero_reg_bypass observed=%h required=%h", observed, expected);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] reg8;
    logic [31:0] both;
    reg8 = $urandom;
    both = $urandom;
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd8, reg8, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd8);
    expected = {32'h22222222, reg8, 32'h22222222, reg8};
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL bypass_port1 observed=%h required=%h", observed, expected);
    end
    applyStimulus(1'b1, 1'b1, 5'd9, both, 1'b1, 5'd9, 5'd9);
    expected = {both, both, both, both};
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL bypass_both observed=%h required=%h", observed, expected);
    end
    applyStimulus(1'b1, 1'b1, 5'd8, 32'h0BADF00D, 1'b1, 5'd7, 5'd8);
    expected = {32'h22222222, 32'h0BADF00D, 32'h22222222, 32'h0BADF00D};
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL bypass_port2 observed=%h required=%h", observed, expected);
    end
  endtask

  task automatic test_hold_under_write();
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 5'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
    expected = {32'h3, 32'h3, 32'h3, 32'h3};
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL hold_initial_read observed=%h required=%h", observed, expected);
    end
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 5'd3);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL hold_under_write observed=%h required=%h", observed, expected);
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3);
    expected = {32'h33, 32'h33, 32'h33, 32'h33};
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL hold_then_read observed=%h required=%h", observed, expected);
    end
  endtask

  task automatic test_reset_priority();
    applyStimulus(1'b1, 1'b1, 5'd5, 32'h55555555, 1'b1, 5'd5, 5'd5);
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 5'd5);
    checks++;
    if (observed !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_priority_out observed=%h required=%h", observed, 128'h0);
    end
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5);
    checks++;
    if (observed !== 128'h0) begin
      failures++;
      $display("[TB] FAIL reset_priority_reg observed=%h required=%h", observed, 128'h0);
    end
  endtask

  task automatic test_random();
    logic rst;
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 31) != 0);
      applyStimulus(rst, 1'($urandom), 5'($urandom), $urandom, 1'($urandom),
                    5'($urandom), 5'($urandom));
      expected = {expZeroR1, expZeroR2, expPlainR1, expPlainR2};
      checks++;
      if (observed !== expected) begin
        failures++;
        $display("[TB] FAIL random cycle=%0d observed=%h required=%h", n, observed, expected);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_write_read_all();
    test_zero_reg();
    test_bypass();
    test_hold_under_write();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
